ff_triplet_checker: RTL

Self-checking monitor directly downstream of the SR/JK/T-built D flip-flop stage. It takes the same `D` stream driven into that stage and the three `Q` outputs. It checks, every clock after a warm-up window, that each `Q` equals the `D` captured one edge earlier. Mismatches are accumulated in saturating per-flop counters, sticky fault flags and a first-fault timestamp, so the lab bench and on-chip debug can confirm equivalence of the three implementations.

---
 rtl/ff_chk_pkg.sv | 16 +
 rtl/sat_counter.sv | 27 ++
 rtl/ff_triplet_checker.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ff_chk_pkg.sv
// Shared types and constants for the D/SR/JK/T flip-flop equivalence checker.
// The state enum and fault_vec bit positions are shared by RTL and debug tooling.
package ff_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    CHECK  = 2'd2
  } chk_state_e;

  localparam int NUM_FF = 3;
  localparam int FV_SR  = 0;
  localparam int FV_JK  = 1;
  localparam int FV_T   = 2;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over increment.
// The reset input is asynchronous and active-low.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg <= '0;
    end else if (clr) begin
      q_reg <= '0;
    end else if (inc && (q_reg != {W{1'b1}})) begin
      q_reg <= q_reg + W'(1);
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/ff_triplet_checker.sv
// Compares three flip-flop implementations against the D stream delayed by one edge,
// accumulating saturating mismatch counts, sticky flags and a first-fault timestamp.
module ff_triplet_checker
  import ff_chk_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int TS_W   = 16,
  parameter int WARMUP = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             d_in,
  input  logic             q_sr,
  input  logic             q_jk,
  input  logic             q_t,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       fault_vec,
  output logic [CNT_W-1:0] err_cnt_sr,
  output logic [CNT_W-1:0] err_cnt_jk,
  output logic [CNT_W-1:0] err_cnt_t,
  output logic [TS_W-1:0]  cycle_cnt,
  output logic [TS_W-1:0]  first_fault_ts
);

  chk_state_e          state_reg, state_next;
  logic [7:0]          warm_reg, warm_next;
  logic                d_q_reg;
  logic [NUM_FF-1:0]   fault_vec_reg, fault_vec_next;
  logic [TS_W-1:0]     ts_reg, ts_next;
  logic                clr;
  logic                in_check;
  logic [NUM_FF-1:0]   q_vec;
  logic [NUM_FF-1:0]   mis;
  logic [CNT_W-1:0]    err_cnt_vec [NUM_FF];

  assign q_vec[FV_SR] = q_sr;
  assign q_vec[FV_JK] = q_jk;
  assign q_vec[FV_T]  = q_t;

  assign in_check = (state_reg == CHECK);
  // d_q_reg holds the D captured one edge ago, which is what every Q should show now
  assign mis = in_check ? (q_vec ^ {NUM_FF{d_q_reg}}) : '0;

  always_comb begin
    state_next = state_reg;
    warm_next  = warm_reg;
    clr        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = ff_chk_pkg::WARMUP;
          warm_next  = 8'(WARMUP - 1);
          clr        = 1'b1;
        end
      end
      ff_chk_pkg::WARMUP: begin
        if (stop) begin
          state_next = IDLE;
        end else if (warm_reg == 8'd0) begin
          state_next = CHECK;
        end else begin
          warm_next = warm_reg - 8'd1;
        end
      end
      CHECK: begin
        if (stop) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fault_vec_next = fault_vec_reg | mis;
    ts_next        = ts_reg;
    if (clr) begin
      fault_vec_next = '0;
      ts_next        = '0;
    end else if ((fault_vec_reg == '0) && (mis != '0)) begin
      ts_next = cycle_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      warm_reg      <= 8'd0;
      d_q_reg       <= 1'b0;
      fault_vec_reg <= '0;
      ts_reg        <= '0;
    end else begin
      state_reg     <= state_next;
      warm_reg      <= warm_next;
      d_q_reg       <= d_in;
      fault_vec_reg <= fault_vec_next;
      ts_reg        <= ts_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_FF; gi++) begin : g_err
      sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (mis[gi]),
        .q     (err_cnt_vec[gi])
      );
    end
  endgenerate

  sat_counter #(.W(TS_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (in_check),
    .q     (cycle_cnt)
  );

  assign busy           = (state_reg != IDLE);
  assign fault_vec      = fault_vec_reg;
  assign fault          = |fault_vec_reg;
  assign first_fault_ts = ts_reg;
  assign err_cnt_sr     = err_cnt_vec[FV_SR];
  assign err_cnt_jk     = err_cnt_vec[FV_JK];
  assign err_cnt_t      = err_cnt_vec[FV_T];

endmodule
